fir_decim_dac_fmt: RTL and testbench
====================================

Name: fir_decim_dac_fmt

Overview:
- Downstream consumer of the FIR low-pass stage's signed output stream (data plus one-cycle valid).
- Box-car averages DECIM consecutive valid samples, decimates by DECIM, applies a power-of-two gain with saturation, and converts to offset-binary.
- Output is a held word in the AD9764 DAC format, driving the DAC interface block.

Parameters:
- IN_W, 12: width of signed input samples.
- OUT_W, 14: width of the offset-binary DAC word.
- DECIM_LOG2, 2: log2 of the decimation/averaging length. DECIM = 2^DECIM_LOG2. Legal range 0..6.
- GAIN_SHIFT, 2: left shift applied after averaging. Legal range 0..8.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  IN_W  signed two's-complement FIR output sample.
- in_valid  in  1  qualifies in_data. Any duty cycle is allowed, with arbitrary gaps.
- clr_sat  in  1  synchronous clear of sat_flag.
- dac_data  out  OUT_W  offset-binary DAC word, held between updates.
- out_valid  out  1  one-cycle pulse when dac_data updates.
- sat_flag  out  1  sticky saturation indicator.

Behaviour:
- Internal state:
  - acc: signed, IN_W+DECIM_LOG2 bits.
  - cnt: DECIM_LOG2 bits; absent or constant 0 when DECIM_LOG2=0.
- Reset values, when rst=1 at a clock edge:
  - acc=0, cnt=0, out_valid=0, sat_flag=0.
  - dac_data = 2^(OUT_W-1), i.e. 8192 mid-scale (analog zero).
  - Reset overrides every other input in that cycle, including a block in progress. A partial sum is discarded.
- Cycle with in_valid=0: acc, cnt and dac_data hold. out_valid=0.
- Cycle with in_valid=1 and cnt<DECIM-1: acc += sign-extended in_data, cnt++. out_valid=0.
- Cycle with in_valid=1 and cnt==DECIM-1 (block completes):
  - sum = acc + in_data, computed at full width with no wrap.
  - avg = sum >>> DECIM_LOG2. This is an arithmetic shift with floor rounding toward -inf.
  - scaled = avg <<< GAIN_SHIFT, computed at IN_W+GAIN_SHIFT bits.
  - Saturation: if scaled > 2^(OUT_W-1)-1, clamp to 2^(OUT_W-1)-1. If scaled < -2^(OUT_W-1), clamp to -2^(OUT_W-1). Either clamp sets sat_flag.
  - Format: dac_data = clamped value with its MSB inverted, equivalent to adding 2^(OUT_W-1).
  - acc=0, cnt=0, out_valid=1.
  - Both clamp limits are inclusive: a value exactly at the limit passes and does not set sat_flag.
- Latency: dac_data and out_valid are registered one clk after the edge that samples the completing in_valid.
- out_valid is high for exactly one cycle per DECIM accepted samples, and is never high two consecutive cycles unless DECIM=1 and in_valid is continuous.
- DECIM_LOG2=0: every valid sample passes through with gain and saturation only. Latency is 1.
- sat_flag:
  - Set by any clamp.
  - Cleared by clr_sat=1.
  - If a clamp and clr_sat occur in the same cycle, set wins.
  - Not cleared by out_valid.
- There is no backpressure. The block always accepts in_valid.
- Defaults give an output range of -8192..8188, so no saturation occurs with defaults.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst 3 cycles, then idle 10 cycles -> dac_data=8192, out_valid=0, sat_flag=0 throughout.
- Defaults, in_valid continuous with 100,200,300,400 -> sum 1000, avg 250, scaled 1000. dac_data=9192 with out_valid pulsed one cycle after the 4th valid. No pulse on valids 1-3.
- Floor rounding with inputs -1,-1,-1,-2 -> sum -5, avg -2, scaled -8 -> dac_data=8184.
- Gapped valid: same 100..400 sequence with 0-5 idle cycles between samples -> identical 9192. A single pulse, one cycle after the 4th valid. dac_data holds 9192 through a following partial block.
- Saturation with GAIN_SHIFT=3:
  - Four 2047 samples -> scaled 16376, clamp to 8191 -> dac_data=16383, sat_flag=1.
  - Pulse clr_sat -> sat_flag=0.
  - Four -2048 samples -> scaled -16384, clamp to -8192 -> dac_data=0, sat_flag=1.
  - clr_sat held high during this block -> sat_flag=1 still (set wins).
- Reset mid-block: two valids of 2000, then rst one cycle, then four valids of 40 -> dac_data=8352 (8192+160). No pulse until the 4th post-reset valid.

Source files
------------

// File: rtl/fir_decim_dac_fmt.sv
// Box-car average and decimate a signed sample stream, apply a power-of-two gain
// with saturation, and hold the result as an offset-binary DAC word.
module fir_decim_dac_fmt #(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 14,
  parameter int DECIM_LOG2 = 2,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  input  logic                    clr_sat,
  output logic [OUT_W-1:0]        dac_data,
  output logic                    out_valid,
  output logic                    sat_flag
);

  localparam int AW  = IN_W + DECIM_LOG2;
  localparam int SCW = IN_W + GAIN_SHIFT;
  // One spare bit over the wider of scaled/output so both limits compare as signed
  localparam int SW  = ((SCW > OUT_W) ? SCW : OUT_W) + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  logic signed [AW-1:0]   acc_reg;
  logic signed [AW-1:0]   sum_next;
  logic signed [IN_W-1:0] avg_next;
  logic signed [SCW-1:0]  scaled_next;
  logic signed [SW-1:0]   wide_next;
  logic [OUT_W-1:0]       clamped_next;
  logic                   sat_hit_next;
  logic                   last_sample;
  logic [OUT_W-1:0]       dac_reg;
  logic                   out_valid_reg;
  logic                   sat_reg;

  generate
    if (DECIM_LOG2 > 0) begin : g_cnt
      logic [DECIM_LOG2-1:0] cnt_reg;

      // Counter wraps naturally from DECIM-1 back to 0 on the completing sample
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (in_valid) begin
          cnt_reg <= cnt_reg + DECIM_LOG2'(1);
        end
      end

      assign last_sample = &cnt_reg;
    end else begin : g_nocnt
      assign last_sample = 1'b1;
    end
  endgenerate

  always_comb begin
    sum_next     = acc_reg + AW'(in_data);
    avg_next     = IN_W'(sum_next >>> DECIM_LOG2);
    scaled_next  = SCW'(avg_next) <<< GAIN_SHIFT;
    wide_next    = SW'(scaled_next);
    clamped_next = wide_next[OUT_W-1:0];
    sat_hit_next = 1'b0;
    if (wide_next > MAX_V) begin
      clamped_next = MAX_V[OUT_W-1:0];
      sat_hit_next = 1'b1;
    end else if (wide_next < MIN_V) begin
      clamped_next = MIN_V[OUT_W-1:0];
      sat_hit_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      dac_reg       <= {1'b1, {(OUT_W-1){1'b0}}};
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid & last_sample;
      if (in_valid) begin
        if (last_sample) begin
          acc_reg <= '0;
          dac_reg <= {~clamped_next[OUT_W-1], clamped_next[OUT_W-2:0]};
        end else begin
          acc_reg <= sum_next;
        end
      end
    end
  end

  // A clamp in the same cycle as clr_sat keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_reg <= 1'b0;
    end else if (in_valid && last_sample && sat_hit_next) begin
      sat_reg <= 1'b1;
    end else if (clr_sat) begin
      sat_reg <= 1'b0;
    end
  end

  assign dac_data  = dac_reg;
  assign out_valid = out_valid_reg;
  assign sat_flag  = sat_reg;

endmodule

// File: tb/tb_fir_decim_dac_fmt.sv
// Scoreboard bench: one DUT at default gain and one at GAIN_SHIFT=3 share the same stimulus.
module tb_fir_decim_dac_fmt;

  logic clk = 1'b0;
  logic rst;
  logic clr_sat;
  logic in_valid;
  logic signed [11:0] in_data;
  logic [13:0] dac2, dac3;
  logic ov2, ov3, sat2, sat3;

  typedef struct packed {
    logic [13:0] dac;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  fir_decim_dac_fmt u_g2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clr_sat(clr_sat),
    .dac_data(dac2), .out_valid(ov2), .sat_flag(sat2)
  );

  fir_decim_dac_fmt #(.GAIN_SHIFT(3)) u_g3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clr_sat(clr_sat),
    .dac_data(dac3), .out_valid(ov3), .sat_flag(sat3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse pops and checks the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (ov2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL g2_spurious_pulse: got pulse with dac=%0d expected none (cycle %0d)", dac2, cyc);
      end else begin
        e = q2.pop_front();
        check("g2_dac", int'(dac2), int'(e.dac));
        check("g2_sat", int'(sat2), int'(e.sat));
        check("g2_latency_cycle", cyc, e.cyc);
        $display("g2 pulse: dac=%0d sat=%0d cycle=%0d", dac2, sat2, cyc);
      end
    end
    if (ov3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL g3_spurious_pulse: got pulse with dac=%0d expected none (cycle %0d)", dac3, cyc);
      end else begin
        e = q3.pop_front();
        check("g3_dac", int'(dac3), int'(e.dac));
        check("g3_sat", int'(sat3), int'(e.sat));
        check("g3_latency_cycle", cyc, e.cyc);
        $display("g3 pulse: dac=%0d sat=%0d cycle=%0d", dac3, sat3, cyc);
      end
    end
  end

  task automatic check_state(input string tag, input int e2, input int e3, input int es2, input int es3);
    check({tag, "_g2_dac"}, int'(dac2), e2);
    check({tag, "_g3_dac"}, int'(dac3), e3);
    check({tag, "_g2_valid"}, int'(ov2), 0);
    check({tag, "_g3_valid"}, int'(ov3), 0);
    check({tag, "_g2_sat"}, int'(sat2), es2);
    check({tag, "_g3_sat"}, int'(sat3), es3);
  endtask

  // Called at a negedge; the following posedge samples the value
  task automatic sample(input int d, input bit last,
                        input int e2, input bit s2, input int e3, input bit s3);
    in_data  = 12'(d);
    in_valid = 1'b1;
    if (last) begin
      q2.push_back('{dac: 14'(e2), sat: s2, cyc: cyc + 1});
      q3.push_back('{dac: 14'(e3), sat: s3, cyc: cyc + 1});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic block(input int d[4], input int gap[4],
                       input int e2, input bit s2, input int e3, input bit s3);
    for (int i = 0; i < 4; i++) begin
      repeat (gap[i]) @(negedge clk);
      sample(d[i], i == 3, e2, s2, e3, s3);
    end
    $display("block issued: %0d %0d %0d %0d -> g2 %0d, g3 %0d", d[0], d[1], d[2], d[3], e2, e3);
  endtask

  initial begin
    rst      = 1'b1;
    clr_sat  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      check_state("reset_idle", 8192, 8192, 0, 0);
    end

    block('{100, 200, 300, 400}, '{0, 0, 0, 0}, 9192, 1'b0, 10192, 1'b0);
    repeat (3) @(negedge clk);
    block('{-1, -1, -1, -2}, '{0, 0, 0, 0}, 8184, 1'b0, 8176, 1'b0);
    repeat (3) @(negedge clk);
    block('{100, 200, 300, 400}, '{2, 5, 0, 3}, 9192, 1'b0, 10192, 1'b0);

    // Partial block must leave the held word untouched, then reset discards it
    sample(2000, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    sample(2000, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_state("hold_partial", 9192, 10192, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_state("mid_block_reset", 8192, 8192, 0, 0);
    block('{40, 40, 40, 40}, '{0, 1, 0, 2}, 8352, 1'b0, 8512, 1'b0);
    repeat (3) @(negedge clk);

    block('{2047, 2047, 2047, 2047}, '{0, 0, 0, 0}, 16380, 1'b0, 16383, 1'b1);
    repeat (2) @(negedge clk);
    check_state("sat_sticky", 16380, 16383, 0, 1);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    @(negedge clk);
    check_state("sat_cleared", 16380, 16383, 0, 0);

    clr_sat = 1'b1;
    block('{-2048, -2048, -2048, -2048}, '{0, 0, 0, 0}, 0, 1'b0, 0, 1'b1);
    clr_sat = 1'b0;
    repeat (3) @(negedge clk);
    check_state("sat_set_wins", 0, 0, 0, 1);

    for (int i = 0; i < 50 && (q2.size() + q3.size()) != 0; i++) @(negedge clk);
    check("scoreboard_drained", q2.size() + q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
